// File: rtl/fib_result_checker.sv
// fib_result_checker
//   Walks register-file entries 0..15 after the Fibonacci test FSM has filled
//   them. Each entry is compared with an internally generated Fibonacci
//   sequence (1, 2, 3, 5, ...). The block latches per-register mismatch flags
//   and drives the last sampled index and value for the hex display.
//
//   Optional build macro: FIB_CHECK_DWELL_EN
//     When defined, each register is held on the display for DWELL_CYCLES
//     extra cycles. When undefined, the scan runs at one register per cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin scan (sampled only in IDLE)
//   rd_sel     register-file read address
//   rd_data    register-file read data (combinational from rd_sel)
//   disp_index index of last sampled register
//   disp_value value of last sampled register
//   busy       scan in progress
//   done       scan finished, results held
//   pass/fail  done with zero / non-zero mismatches
//   err_mask   bit i set if register i mismatched
//   err_count  number of mismatches (0..16)
module fib_result_checker #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned DWELL_CYCLES = 50000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [3:0]            rd_sel,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [3:0]            disp_index,
   output logic [DATA_WIDTH-1:0] disp_value,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  fail,
   output logic [15:0]           err_mask,
   output logic [4:0]            err_count
);

   if (DWELL_CYCLES < 1) begin : g_bad_dwell
      $error("DWELL_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
`ifdef FIB_CHECK_DWELL_EN
      DWELL = 2'd2,
`endif
      DONE  = 2'd3
   } state_t;

   state_t                state, state_next;
   logic [3:0]            idx;
   logic [DATA_WIDTH-1:0] exp_a, exp_b;
   logic                  last_idx;
   logic                  mismatch;
`ifdef FIB_CHECK_DWELL_EN
   logic [31:0]           dwell_cnt;
`endif

   assign last_idx = (idx == 4'd15);
   assign mismatch = (rd_data != exp_a);

   // idx is forced to 0 in IDLE, so the read address can follow it directly
   assign rd_sel = idx;
   assign pass   = done && (err_count == 5'd0);
   assign fail   = done && (err_count != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = READ;
         end
         READ: begin
            busy = 1'b1;
`ifdef FIB_CHECK_DWELL_EN
            state_next = DWELL;
`else
            if (last_idx) state_next = DONE;
`endif
         end
`ifdef FIB_CHECK_DWELL_EN
         DWELL: begin
            busy = 1'b1;
            if (dwell_cnt == 32'd0) state_next = last_idx ? DONE : READ;
         end
`endif
         DONE: begin
            done = 1'b1;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         exp_a      <= DATA_WIDTH'(1);
         exp_b      <= DATA_WIDTH'(2);
         disp_index <= '0;
         disp_value <= '0;
         err_mask   <= '0;
         err_count  <= '0;
`ifdef FIB_CHECK_DWELL_EN
         dwell_cnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               idx   <= '0;
               exp_a <= DATA_WIDTH'(1);
               exp_b <= DATA_WIDTH'(2);
            end
            READ: begin
               disp_index <= idx;
               disp_value <= rd_data;
               if (mismatch) begin
                  err_mask[idx] <= 1'b1;
                  err_count     <= err_count + 5'd1;
               end
               exp_a <= exp_b;
               exp_b <= exp_a + exp_b;
`ifdef FIB_CHECK_DWELL_EN
               dwell_cnt <= DWELL_CYCLES - 32'd1;
`else
               if (!last_idx) idx <= idx + 4'd1;
`endif
            end
`ifdef FIB_CHECK_DWELL_EN
            DWELL: begin
               if (dwell_cnt == 32'd0) begin
                  if (!last_idx) idx <= idx + 4'd1;
               end else begin
                  dwell_cnt <= dwell_cnt - 32'd1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fib_result_checker.sv
// Scoreboard bench for fib_result_checker. The stimulus pushes the expected
// read sequence and final result into queues. A negedge monitor pops entries
// and compares them whenever the DUT starts a new read or raises done.
module tb_fib_result_checker;
   localparam int unsigned DW    = 16;
   localparam int unsigned DWELL = 3;
`ifdef FIB_CHECK_DWELL_EN
   localparam int unsigned SCAN_EDGES = 1 + 16 * (1 + DWELL);
`else
   localparam int unsigned SCAN_EDGES = 17;
`endif

   logic          clk = 1'b0;
   logic          rst, start;
   logic [3:0]    rd_sel, disp_index;
   logic [DW-1:0] rd_data, disp_value;
   logic          busy, done, pass, fail;
   logic [15:0]   err_mask;
   logic [4:0]    err_count;

   fib_result_checker #(.DATA_WIDTH(DW), .DWELL_CYCLES(DWELL)) dut (
      .clk(clk), .rst(rst), .start(start), .rd_sel(rd_sel), .rd_data(rd_data),
      .disp_index(disp_index), .disp_value(disp_value), .busy(busy), .done(done),
      .pass(pass), .fail(fail), .err_mask(err_mask), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int unsigned edge_n = 0;
   always @(posedge clk) edge_n++;

   logic [DW-1:0] regs [16];
   always_comb rd_data = regs[rd_sel];

   logic [DW-1:0] fib_tab [16] = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
      16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610,
      16'd987, 16'd1597};

   typedef struct { logic [3:0] idx; logic [DW-1:0] val; } rd_t;
   typedef struct {
      logic [15:0] mask; logic [4:0] cnt; logic pass; logic fail; int unsigned edge_at;
   } res_t;
   rd_t  rd_q [$];
   res_t res_q [$];

   int compared   = 0;
   int mismatched = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   // monitor
   bit         disp_pend = 0;
   rd_t        disp_exp;
   res_t       r;
   logic       done_d = 1'b0, busy_d = 1'b0;
   logic [3:0] sel_d = '0;
   always @(negedge clk) begin
      if (disp_pend) begin
         check("disp_index", 32'(disp_index), 32'(disp_exp.idx));
         check("disp_value", 32'(disp_value), 32'(disp_exp.val));
         disp_pend = 0;
      end
      if (rst) begin
         rd_q.delete();
         disp_pend = 0;
      end else if (busy && (!busy_d || rd_sel != sel_d)) begin
         if (rd_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_read: rd_sel=%0d with no read expected", rd_sel);
         end else begin
            disp_exp = rd_q.pop_front();
            check("rd_sel", 32'(rd_sel), 32'(disp_exp.idx));
            disp_pend = 1;
         end
      end
      if (done && !done_d) begin
         if (res_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: done rose with no result expected");
         end else begin
            r = res_q.pop_front();
            check("done_edge", edge_n, r.edge_at);
            check("err_mask", 32'(err_mask), 32'(r.mask));
            check("err_count", 32'(err_count), 32'(r.cnt));
            check("pass", 32'(pass), 32'(r.pass));
            check("fail", 32'(fail), 32'(r.fail));
         end
      end
      done_d = done;
      busy_d = busy;
      sel_d  = rd_sel;
   end

   task automatic check_reset(string tag);
      check({tag, "_rd_sel"}, 32'(rd_sel), 0);
      check({tag, "_disp_index"}, 32'(disp_index), 0);
      check({tag, "_disp_value"}, 32'(disp_value), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_pass"}, 32'(pass), 0);
      check({tag, "_fail"}, 32'(fail), 0);
      check({tag, "_err_mask"}, 32'(err_mask), 0);
      check({tag, "_err_count"}, 32'(err_count), 0);
   endtask

   task automatic load_good();
      for (int i = 0; i < 16; i++) regs[i] = fib_tab[i];
   endtask

   task automatic do_reset(string tag);
      @(posedge clk); #1 rst = 1'b1;
      res_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      check_reset(tag);
   endtask

   // Push expectations, then drive start right after edge k.
   task automatic issue_scan(input logic [15:0] mask, input logic [4:0] cnt);
      res_t e;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) rd_q.push_back('{idx: 4'(i), val: regs[i]});
      e.mask = mask; e.cnt = cnt; e.pass = (cnt == 0); e.fail = (cnt != 0);
      e.edge_at = edge_n + SCAN_EDGES;
      res_q.push_back(e);
      start = 1'b1;
   endtask

   task automatic wait_done(string tag);
      for (int i = 0; i < 200 && !done; i++) @(posedge clk);
      #1;
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL %s_timeout: done=%0d required 1", tag, done);
      end
   endtask

   task automatic run_scan(string tag, input logic [15:0] mask, input logic [4:0] cnt);
      issue_scan(mask, cnt);
      @(posedge clk); #1 start = 1'b0;
      wait_done(tag);
      repeat (2) @(posedge clk);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      load_good();
      repeat (3) @(posedge clk);
      #1 check_reset("por");
      rst = 1'b0;

      // correct register file
      run_scan("good", 16'h0000, 5'd0);
      check("good_disp_index", 32'(disp_index), 15);
      check("good_disp_value", 32'(disp_value), 1597);
      do_reset("rst1");

      // reg7 corrupted
      regs[7] = '0;
      run_scan("reg7", 16'h0080, 5'd1);
      do_reset("rst2");

      // all-zero register file
      for (int i = 0; i < 16; i++) regs[i] = '0;
      run_scan("zero", 16'hFFFF, 5'd16);
      do_reset("rst3");

      // start held high through and after DONE
      load_good();
      issue_scan(16'h0000, 5'd0);
      wait_done("hold");
      repeat (20) @(posedge clk);
      #1;
      check("hold_done", 32'(done), 1);
      check("hold_busy", 32'(busy), 0);
      check("hold_err_count", 32'(err_count), 0);
      check("hold_err_mask", 32'(err_mask), 0);
      start = 1'b0;
      do_reset("rst4");

      // reset while reading register 5
      begin
         bit hit = 0;
         issue_scan(16'h0000, 5'd0);
         @(posedge clk); #1 start = 1'b0;
         for (int i = 0; i < 40 && !hit; i++) begin
            if (rd_sel == 4'd5 && busy) hit = 1;
            else begin @(posedge clk); #1; end
         end
         check("mid_reached_idx5", 32'(rd_sel), 5);
         rst = 1'b1;
         res_q.delete();
         @(posedge clk); #1 rst = 1'b0;
         check_reset("mid");
      end
      run_scan("rescan", 16'h0000, 5'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
